sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Synchronous SRAM-like responder: the memory end of the CPU's inst/data SRAM interface (en, wen, addr, wdata, rdata).
- Models on-chip RAM with a fixed 1-cycle read latency and byte-lane writes.
- Translates kseg0/kseg1 virtual addresses to physical addresses and decodes a single window.
- Provides a backdoor preload port for the bench, plus access counters for performance debug.

Parameters:
- DEPTH_LOG2, 14, log2 of the number of 32-bit words stored (16K words = 64 KB).
- BASE_PADDR, 32'h1fc00000, physical byte address of word 0; must be 4-byte aligned.
- OOR_RDATA, 32'h00000000, read data returned for out-of-window reads.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- sram_en  in  1  access request this cycle
- sram_wen  in  4  byte-lane write enables; 0 = read
- sram_addr  in  32  virtual byte address
- sram_wdata  in  32  write data, lane i = bits [8i+7:8i]
- sram_rdata  out  32  registered read data
- sram_err  out  1  registered out-of-window flag, aligned with sram_rdata
- init_we  in  1  backdoor word write
- init_idx  in  DEPTH_LOG2  backdoor word index
- init_data  in  32  backdoor word data
- rd_cnt  out  32  count of accepted reads
- wr_cnt  out  32  count of accepted writes

Behaviour:
- Reset: already decided — reset reset, synchronous, active-high; clock clk.
  - During reset, sram_rdata=0, sram_err=0, rd_cnt=0, wr_cnt=0.
  - Memory array is not cleared. init_we is honoured during reset so the bench can preload.
  - sram_en is ignored while reset is high.
- Address path:
  - paddr = {3'b000, sram_addr[28:0]} (kseg0/kseg1 strip).
  - off = paddr - BASE_PADDR (32-bit unsigned).
  - In window iff off < 4<<DEPTH_LOG2; word index = off[DEPTH_LOG2+1:2].
  - sram_addr[1:0] are ignored; there is no misalignment error.
- Read (sram_en=1, sram_wen=0):
  - At the next posedge, sram_rdata = mem[idx] and sram_err = 0.
  - If out of window: sram_rdata = OOR_RDATA, sram_err = 1.
  - rd_cnt increments.
- Write (sram_en=1, sram_wen!=0):
  - Only enabled lanes of mem[idx] are updated. Out-of-window writes are dropped.
  - Read-first: sram_rdata takes the old word (or OOR_RDATA), and sram_err is set as for a read.
  - wr_cnt increments, including for dropped writes.
- Hold: when sram_en=0, sram_rdata and sram_err keep their values indefinitely. A stalled fetch stage depends on this.
- Back-to-back: one access per cycle, every cycle, with no bubbles and no backpressure.
  - A read of a word written in the previous cycle returns the new data.
- Simultaneous init_we and sram write to the same index:
  - Apply init_data first, then overlay the sram_wdata lanes enabled by sram_wen.
  - Net effect: sram lanes win, unenabled lanes take init_data.
- init_we never affects sram_rdata, sram_err or the counters.
- Counters saturate at 32'hffffffff; they do not wrap.
- Reset mid-operation: the access presented in the same cycle as reset is discarded. Outputs read 0 on the cycle after reset deasserts until the next access.

Test Plan:
- Preload via init: idx 0 = 32'h3c1d0001. Read sram_addr=32'hbfc00000, then 32'h9fc00000 -> sram_rdata=32'h3c1d0001 one cycle later for both, sram_err=0, rd_cnt=2.
- Partial write at 32'hbfc00010 (word 4 = 32'h11223344), wen=4'b0101, wdata=32'haabbccdd -> the write cycle returns 32'h11223344 (read-first). A following read returns 32'h11bb33dd. wr_cnt=1.
- Hold: read word 0, then sram_en=0 for 5 cycles while init_we rewrites idx 0 -> sram_rdata stays 32'h3c1d0001 throughout.
- Out of window: read 32'hbfbffffc and 32'hbfc00000+(4<<DEPTH_LOG2) -> sram_rdata=OOR_RDATA, sram_err=1. A write there leaves memory unchanged and increments wr_cnt.
- Collision: same cycle init_we idx 2 data 32'hffffffff plus sram write word 2 with wen=4'b0011, wdata=0 -> a later read returns 32'hffff0000.
- Reset mid-stream: reset asserted during an active read burst -> rdata=0, err=0 and counters=0 the next cycle. A subsequent read of preloaded idx 0 still returns 32'h3c1d0001.

Source files
------------

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - SRAM-like memory responder with kseg strip, window decode, byte lanes and access counters
module sram_responder #(
  parameter int          DEPTH_LOG2 = 14,
  parameter logic [31:0] BASE_PADDR = 32'h1fc00000,
  parameter logic [31:0] OOR_RDATA  = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sram_en,
  input  logic [3:0]            sram_wen,
  input  logic [31:0]           sram_addr,
  input  logic [31:0]           sram_wdata,
  output logic [31:0]           sram_rdata,
  output logic                  sram_err,
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_idx,
  input  logic [31:0]           init_data,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH) << 2;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           paddr;
  logic [31:0]           off;
  logic                  in_win;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           base_word;
  logic [31:0]           merged_word;
  logic                  wr_hit;
  logic                  unused_bits;

  always_comb begin
    paddr  = {3'b000, sram_addr[28:0]};
    off    = paddr - BASE_PADDR;
    in_win = off < WIN_BYTES;
    idx    = off[DEPTH_LOG2+1:2];
    wr_hit = !reset && sram_en && (sram_wen != 4'b0000) && in_win;
    // A same-cycle backdoor write to this word lands first; enabled sram lanes overlay it.
    base_word = (init_we && init_idx == idx) ? init_data : mem[idx];
    merged_word = base_word;
    for (int i = 0; i < 4; i++) begin
      if (sram_wen[i]) merged_word[8*i +: 8] = sram_wdata[8*i +: 8];
    end
  end

  assign unused_bits = ^{sram_addr[31:29], off[1:0]};

  always_ff @(posedge clk) begin
    if (init_we) mem[init_idx] <= init_data;
    if (wr_hit)  mem[idx] <= merged_word;
  end

  // Read-first: the response carries the word as it was before any write this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_rdata <= 32'h0;
      sram_err   <= 1'b0;
      rd_cnt     <= 32'h0;
      wr_cnt     <= 32'h0;
    end else if (sram_en) begin
      sram_rdata <= in_win ? mem[idx] : OOR_RDATA;
      sram_err   <= !in_win;
      if (sram_wen != 4'b0000) begin
        if (wr_cnt != 32'hffffffff) wr_cnt <= wr_cnt + 32'd1;
      end else begin
        if (rd_cnt != 32'hffffffff) rd_cnt <= rd_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - scoreboard bench for sram_responder with directed vectors
module tb_sram_responder;

  localparam int DL2 = 14;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           sram_en = 1'b0;
  logic [3:0]     sram_wen = 4'b0;
  logic [31:0]    sram_addr = 32'h0;
  logic [31:0]    sram_wdata = 32'h0;
  logic [31:0]    sram_rdata;
  logic           sram_err;
  logic           init_we = 1'b0;
  logic [DL2-1:0] init_idx = '0;
  logic [31:0]    init_data = 32'h0;
  logic [31:0]    rd_cnt;
  logic [31:0]    wr_cnt;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q [$];
  int exp_rd = 0;
  int exp_wr = 0;

  sram_responder #(.DEPTH_LOG2(DL2), .BASE_PADDR(32'h1fc00000), .OOR_RDATA(32'h00000000)) dut (
    .clk(clk), .reset(reset), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_err(sram_err), .init_we(init_we), .init_idx(init_idx),
    .init_data(init_data), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted access yields a response at the next edge.
  initial begin
    logic due;
    logic [32:0] e;
    forever begin
      @(posedge clk);
      due = sram_en && !reset;
      @(negedge clk);
      if (due) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", sram_rdata, e[31:0]);
          check("resp_err", {31'b0, sram_err}, {31'b0, e[32]});
        end
      end
    end
  end

  task automatic access(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err);
    sram_en = 1'b1; sram_wen = wen; sram_addr = addr; sram_wdata = wdata;
    exp_q.push_back({exp_err, exp_data});
    if (wen != 4'b0) exp_wr++; else exp_rd++;
    @(negedge clk);
    sram_en = 1'b0; sram_wen = 4'b0; init_we = 1'b0;
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    init_we = 1'b1; init_idx = DL2'(idx); init_data = data;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_rd_cnt"}, rd_cnt, 32'(exp_rd));
    check({tag, "_wr_cnt"}, wr_cnt, 32'(exp_wr));
  endtask

  initial begin
    @(negedge clk);
    // Preload during reset with a request presented that must be ignored.
    sram_en = 1'b1; sram_addr = 32'hbfc00000;
    preload(0, 32'h3c1d0001);
    preload(4, 32'h11223344);
    preload(2, 32'h00000000);
    preload(16383, 32'h55aa55aa);
    sram_en = 1'b0;
    check("reset_rdata", sram_rdata, 32'h0);
    check("reset_err", {31'b0, sram_err}, 32'h0);
    check_cnts("reset");
    reset = 1'b0;

    access(32'hbfc00000, 4'b0000, 32'h0, 32'h3c1d0001, 1'b0);
    access(32'h9fc00000, 4'b0000, 32'h0, 32'h3c1d0001, 1'b0);
    check_cnts("kseg");

    access(32'hbfc00010, 4'b0101, 32'haabbccdd, 32'h11223344, 1'b0);
    access(32'hbfc00012, 4'b0000, 32'h0, 32'h11bb33dd, 1'b0);
    check_cnts("partial");

    access(32'hbfc00000, 4'b0000, 32'h0, 32'h3c1d0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      preload(0, 32'hdeadbeef);
      check("hold_rdata", sram_rdata, 32'h3c1d0001);
    end
    check("hold_err", {31'b0, sram_err}, 32'h0);
    access(32'hbfc00000, 4'b0000, 32'h0, 32'hdeadbeef, 1'b0);
    preload(0, 32'h3c1d0001);

    access(32'hbfbffffc, 4'b0000, 32'h0, 32'h0, 1'b1);
    access(32'hbfc10000, 4'b0000, 32'h0, 32'h0, 1'b1);
    access(32'hbfc10000, 4'b1111, 32'h12345678, 32'h0, 1'b1);
    access(32'hbfbffffc, 4'b1111, 32'h87654321, 32'h0, 1'b1);
    access(32'hbfc0fffc, 4'b0000, 32'h0, 32'h55aa55aa, 1'b0);
    access(32'hbfc00000, 4'b0000, 32'h0, 32'h3c1d0001, 1'b0);
    check_cnts("oor");

    init_we = 1'b1; init_idx = DL2'(2); init_data = 32'hffffffff;
    access(32'hbfc00008, 4'b0011, 32'h0, 32'h0, 1'b0);
    access(32'hbfc00008, 4'b0000, 32'h0, 32'hffff0000, 1'b0);

    access(32'hbfc00010, 4'b0000, 32'h0, 32'h11bb33dd, 1'b0);
    access(32'h3fc10004, 4'b0000, 32'h0, 32'h0, 1'b1);
    reset = 1'b1; sram_en = 1'b1; sram_addr = 32'hbfc00010;
    @(negedge clk);
    reset = 1'b0; sram_en = 1'b0;
    exp_rd = 0; exp_wr = 0;
    check("midrst_rdata", sram_rdata, 32'h0);
    check("midrst_err", {31'b0, sram_err}, 32'h0);
    check_cnts("midrst");
    @(negedge clk);
    check("postrst_rdata", sram_rdata, 32'h0);
    access(32'hbfc00000, 4'b0000, 32'h0, 32'h3c1d0001, 1'b0);
    check_cnts("final");

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
